div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Iterative 32-bit restoring divider (DIV/DIVU) for the MIPS32 core. The EX stage
//  issues requests and holds stall until ready_o. Result {remainder,quotient} maps to {HI,LO}.
//  One quotient bit per cycle. Signed and unsigned operands.
// PARAMETERS
//  DATA_W   32   operand width; the counter and all widths derive from it
// PORTS
//  clk           in   1        core clock, rising edge
//  rst           in   1        reset, asynchronous assert, active-low (0 = reset)
//  signed_div_i  in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   DATA_W   dividend
//  opdata2_i     in   DATA_W   divisor
//  start_i       in   1        request; EX holds it high until ready_o is seen
//  annul_i       in   1        abort current division (flush)
//  result_o      out  2*DATA_W [63:32] remainder, [31:0] quotient
//  ready_o       out  1        result_o valid
//  divzero_o     out  1        only with DIV_DBZ_FLAG_EN
// BEHAVIOUR
//  - Reset (rst=0, async): state=FREE, cnt=0, ready_o=0, result_o=0, divzero_o=0.
//  - FREE: start_i=1 and annul_i=0 at an edge (E0):
//    - divisor==0 -> BYZERO.
//    - else -> ON with cnt=0.
//      - Latch absolute values when signed_div_i=1; otherwise latch raw operands.
//      - Latch the signs of both operands.
//      - Working reg = {32'b0, |dividend|, 1'b0}.
//    - start_i=1 with annul_i=1 is ignored.
//  - ON: each edge does one step.
//    - t = {1'b0, work[63:32]} - {1'b0, divisor}.
//    - t[32]=1 -> work <<= 1.
//    - t[32]=0 -> work = {t[31:0], work[31:0], 1'b1}.
//    - cnt++ each step; steps run at E1..E32.
//    - After cnt==32, the next edge (E33) enters END. At E33:
//      - quotient = work[31:0], negated if signed and signs differ;
//      - remainder = work[64:33], negated if signed and dividend negative;
//      - register result_o and set ready_o=1.
//  - Latency: ready_o rises at E33 after the accepting edge.
//  - BYZERO: next edge -> END with result_o=0, ready_o=1; latency 2 edges.
//  - END: ready_o and result_o hold while start_i=1.
//    - start_i=0 -> FREE; ready_o=0 and result_o=0 at that edge.
//    - No new request is accepted in END.
//  - annul_i=1 in ON or BYZERO -> FREE next edge; ready_o stays 0; cnt cleared.
//    annul_i is ignored in END and FREE.
//  - start_i dropping mid-ON does not abort; only annul_i aborts.
//  - Operand changes after E0 are ignored (latched).
//  - Signed overflow 0x80000000 / -1 -> quotient 0x80000000, remainder 0; no trap.
//  - Reset asserted mid-operation -> immediate FREE, outputs cleared.
// CONFIGURATION
//  DIV_DBZ_FLAG_EN defined:
//    - adds port divzero_o, registered;
//    - set to 1 on entry to END via BYZERO; cleared when leaving END and by reset.
//  Undefined: no divzero_o port; divide-by-zero is distinguishable only by result 0.
// STRUCTURE
//  - define.v (shared) gets:
//    - state codes DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
//    - DivResultReady / DivResultNotReady;
//    - DivStart / DivStop;
//    - EXE_DIV_OP / EXE_DIVU_OP aluop codes.
//  - Sub-module div_step: combinational single restoring iteration
//    (work_i, divisor_i -> work_o); div instantiates it once.
//  - FSM, counter and sign fix-up stay in div.
// TESTING
//  1. DIVU 100/7 -> ready_o at E33; result_o={32'd2,32'd14}; held until start_i=0.
//  2. DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
//  3. DIVU 0xFFFFFFFF/0x10 -> quotient 0x0FFFFFFF, remainder 0xF.
//     DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//  4. Divisor 0 -> ready_o at E2, result_o=0; divzero_o=1 with DIV_DBZ_FLAG_EN.
//  5. annul_i pulsed at E10 -> FREE at E11, ready_o never rises.
//     Then start 9/3 -> {0,3} at E33.
//  6. rst=0 mid-ON (async, between edges) -> outputs 0 immediately.
//     After release, 20/6 -> {2,3} correct.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state codes, handshake levels, ALU op codes.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the partial remainder and
// shift in the resulting quotient bit.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] work_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W:0]   work_o
);

  logic [DATA_W:0] diff;

  always_comb begin
    diff = {1'b0, work_i[2*DATA_W-1:DATA_W]} - {1'b0, divisor_i};
    if (diff[DATA_W]) begin
      work_o = {work_i, 1'b0};
    end else begin
      work_o = {diff[DATA_W-1:0], work_i[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle; result = {rem, quot}.
// Optional divide-by-zero flag output enabled by defining DIV_DBZ_FLAG_EN.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
`ifdef DIV_DBZ_FLAG_EN
  ,
  output logic                divzero_o
`endif
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W);

  div_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                sign1_q, sign1_d, sign2_q, sign2_d, signed_q, signed_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [2*DATA_W:0]   step_work;
  logic [DATA_W-1:0]   op1_abs, op2_abs, quot_fix, rem_fix;
  logic                accept;

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .work_i    (work_q[2*DATA_W-1:0]),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  assign accept = start_i && !annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivFree:   if (accept) state_d = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q == CntLast) begin
          state_d = DivEnd;
        end
      end
      DivEnd:    if (start_i == DivStop) state_d = DivFree;
      default:   state_d = DivFree;
    endcase
  end

  always_comb begin
    op1_abs  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_fix  = (signed_q && sign1_q) ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];

    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        if (accept && opdata2_i != '0) begin
          cnt_d     = '0;
          work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          divisor_d = op2_abs;
          sign1_d   = opdata1_i[DATA_W-1];
          sign2_d   = opdata2_i[DATA_W-1];
          signed_d  = signed_div_i;
        end
      end
      DivByZero: begin
        if (!annul_i) result_d = '0;
      end
      DivOn: begin
        if (annul_i) begin
          cnt_d = '0;
        end else if (cnt_q != CntLast) begin
          work_d = step_work;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          // The divide-by-zero path reaches END with ready low; raise it here.
          ready_d = DivResultReady;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

`ifdef DIV_DBZ_FLAG_EN
  logic divzero_q, divzero_d;

  always_comb begin
    divzero_d = divzero_q;
    if (state_q == DivByZero && !annul_i) begin
      divzero_d = 1'b1;
    end else if (state_q == DivEnd && start_i == DivStop) begin
      divzero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divzero_q <= 1'b0;
    end else begin
      divzero_q <= divzero_d;
    end
  end

  assign divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the iterative divider: expected results are queued at issue and
// compared when ready_o rises, together with latency, hold and clear behaviour.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;
`ifdef DIV_DBZ_FLAG_EN
  logic        divzero;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] exp_q[$];

  div #(
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
`ifdef DIV_DBZ_FLAG_EN
    ,
    .divzero_o    (divzero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Issue one request, check latency/result/hold; start_i is left high (END holds).
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input logic exp_dz);
    int n;
    logic [63:0] e;
    @(negedge clk);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_eq("e0_ready", 64'(ready), 64'd0);
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~s;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", 64'(n), 64'(exp_lat));
    e = exp_q.pop_front();
    check_eq("result", result, e);
`ifdef DIV_DBZ_FLAG_EN
    check_eq("divzero", 64'(divzero), 64'(exp_dz));
`else
    if (exp_dz) check_eq("dbz_result", result, 64'd0);
`endif
    @(posedge clk);
    #1;
    check_eq("hold_ready", 64'(ready), 64'd1);
    check_eq("hold_result", result, e);
  endtask

  task automatic finish_op();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("clr_ready", 64'(ready), 64'd0);
    check_eq("clr_result", result, 64'd0);
`ifdef DIV_DBZ_FLAG_EN
    check_eq("clr_divzero", 64'(divzero), 64'd0);
`endif
  endtask

  initial begin
    logic seen;
    logic s;
    logic [31:0] a, b;
    rst = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    start = 1'b0;
    annul = 1'b0;
    #1;
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
    finish_op();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
    finish_op();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1'b0);
    finish_op();
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0);
    finish_op();
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0);
    finish_op();
    run_op(1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b1);
    finish_op();

    // start with annul high is ignored
    @(negedge clk);
    op1 = 32'd50;
    op2 = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    check_eq("annul_start_ignored", 64'(seen), 64'd0);
    start = 1'b0;
    annul = 1'b0;

    // Abort mid-division
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    check_eq("annul_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);
    finish_op();

    // Async reset mid-ON, then a clean division
    @(negedge clk);
    op1 = 32'd77;
    op2 = 32'd5;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_on_ready", 64'(ready), 64'd0);
    check_eq("rst_on_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 33, 1'b0);

    // Async reset while END is holding a result
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_end_ready", 64'(ready), 64'd0);
    check_eq("rst_end_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      s = i[0];
      a = $urandom;
      b = (i == 3) ? 32'd1 : ($urandom >> (i * 3));
      if (b == 32'd0) b = 32'd13;
      run_op(s, a, b, model(s, a, b), 33, 1'b0);
      finish_op();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
